// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: IF/ID input, regfile ports, write-back bypass,
// flush/stall control and the ID/EX pipeline register outputs.
interface id_ex_stage_if #(
    parameter int DW = 32
);
    logic          if_id_valid;
    logic [31:0]   if_id_instr;
    logic [DW-1:0] if_id_pc;
    logic [4:0]    rs_addr;
    logic [4:0]    rt_addr;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic          wb_we;
    logic [4:0]    wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          flush;
    logic          stall;
    logic          ex_valid;
    logic [DW-1:0] ex_pc;
    logic [DW-1:0] ex_op1;
    logic [DW-1:0] ex_op2;
    logic [DW-1:0] ex_imm;
    logic [4:0]    ex_waddr;
    logic [2:0]    ex_alu_op;
    logic          ex_alu_src;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic          ex_reg_write;
    logic          ex_mem_to_reg;
    logic          ex_branch;
    logic          ex_illegal;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_issue_cnt;
`endif

    modport master (
`ifdef ID_EX_PERF_CNT_EN
        input  perf_stall_cnt, perf_issue_cnt,
`endif
        output if_id_valid, if_id_instr, if_id_pc, rd1, rd2,
        output wb_we, wb_waddr, wb_wdata, flush,
        input  rs_addr, rt_addr, stall,
        input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_waddr,
        input  ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
        input  ex_reg_write, ex_mem_to_reg, ex_branch, ex_illegal
    );

    modport slave (
`ifdef ID_EX_PERF_CNT_EN
        output perf_stall_cnt, perf_issue_cnt,
`endif
        input  if_id_valid, if_id_instr, if_id_pc, rd1, rd2,
        input  wb_we, wb_waddr, wb_wdata, flush,
        output rs_addr, rt_addr, stall,
        output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_waddr,
        output ex_alu_op, ex_alu_src, ex_mem_read, ex_mem_write,
        output ex_reg_write, ex_mem_to_reg, ex_branch, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// Decode/issue stage: decode, WB bypass, load-use stall, ID/EX register.
// Optional ID_EX_PERF_CNT_EN adds stall/issue performance counters.
module id_ex_stage #(
    parameter int DW = 32,
    parameter bit ILLEGAL_AS_BUBBLE = 1'b1
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;

    assign opcode = bus.if_id_instr[31:26];
    assign funct  = bus.if_id_instr[5:0];
    assign rs     = bus.if_id_instr[25:21];
    assign rt     = bus.if_id_instr[20:16];
    assign rd     = bus.if_id_instr[15:11];

    assign bus.rs_addr = rs;
    assign bus.rt_addr = rt;

    logic is_add, is_sub, is_and, is_or, is_slt, is_r;
    logic is_lw, is_sw, is_beq, is_addi;
    logic [2:0] r_alu_op;

    assign is_add  = (opcode == 6'h00) && (funct == 6'h20);
    assign is_sub  = (opcode == 6'h00) && (funct == 6'h22);
    assign is_and  = (opcode == 6'h00) && (funct == 6'h24);
    assign is_or   = (opcode == 6'h00) && (funct == 6'h25);
    assign is_slt  = (opcode == 6'h00) && (funct == 6'h2A);
    assign is_r    = is_add | is_sub | is_and | is_or | is_slt;
    assign is_lw   = opcode == 6'h23;
    assign is_sw   = opcode == 6'h2B;
    assign is_beq  = opcode == 6'h04;
    assign is_addi = opcode == 6'h08;

    assign r_alu_op = is_sub ? 3'd1 :
                      is_and ? 3'd2 :
                      is_or  ? 3'd3 :
                      is_slt ? 3'd4 : 3'd0;

    logic [2:0] d_alu_op;
    logic       d_alu_src, d_mr, d_mw, d_rw, d_m2r, d_br, d_ill;
    logic       use_rs, use_rt;
    logic [4:0] d_waddr;

    // Instruction decode into control bundle and source usage.
    always_comb begin
        d_alu_op  = 3'd0;
        d_alu_src = 1'b0;
        d_mr      = 1'b0;
        d_mw      = 1'b0;
        d_rw      = 1'b0;
        d_m2r     = 1'b0;
        d_br      = 1'b0;
        d_ill     = 1'b0;
        use_rs    = 1'b0;
        use_rt    = 1'b0;
        d_waddr   = 5'd0;
        unique case (1'b1)
            is_r: begin
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                d_rw     = 1'b1;
                d_waddr  = rd;
                d_alu_op = r_alu_op;
            end
            is_lw: begin
                use_rs    = 1'b1;
                d_alu_src = 1'b1;
                d_mr      = 1'b1;
                d_rw      = 1'b1;
                d_m2r     = 1'b1;
                d_waddr   = rt;
            end
            is_sw: begin
                use_rs    = 1'b1;
                use_rt    = 1'b1;
                d_alu_src = 1'b1;
                d_mw      = 1'b1;
            end
            is_beq: begin
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                d_alu_op = 3'd1;
                d_br     = 1'b1;
            end
            is_addi: begin
                use_rs    = 1'b1;
                d_alu_src = 1'b1;
                d_rw      = 1'b1;
                d_waddr   = rt;
            end
            default: d_ill = 1'b1;
        endcase
    end

    function automatic logic [DW-1:0] pick(
        input logic [4:0]    a,
        input logic [DW-1:0] rdata,
        input logic          we,
        input logic [4:0]    wa,
        input logic [DW-1:0] wd
    );
        if (we && wa != 5'd0 && wa == a) return wd;
        if (a == 5'd0) return '0;
        return rdata;
    endfunction

    logic [DW-1:0] op1, op2, imm;
    logic          hazard, bubble;

    assign op1 = pick(rs, bus.rd1, bus.wb_we, bus.wb_waddr, bus.wb_wdata);
    assign op2 = pick(rt, bus.rd2, bus.wb_we, bus.wb_waddr, bus.wb_wdata);
    assign imm = {{(DW-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};

    assign hazard = bus.ex_valid && bus.ex_mem_read &&
                    bus.ex_waddr != 5'd0 && bus.if_id_valid &&
                    ((use_rs && bus.ex_waddr == rs) ||
                     (use_rt && bus.ex_waddr == rt));

    assign bus.stall = hazard && !bus.flush && !rst;

    assign bubble = bus.flush || hazard || !bus.if_id_valid ||
                    (d_ill && ILLEGAL_AS_BUBBLE);

    // ID/EX pipeline register: bubble or decoded instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            bus.ex_valid      <= 1'b0;
            bus.ex_pc         <= '0;
            bus.ex_op1        <= '0;
            bus.ex_op2        <= '0;
            bus.ex_imm        <= '0;
            bus.ex_waddr      <= 5'd0;
            bus.ex_alu_op     <= 3'd0;
            bus.ex_alu_src    <= 1'b0;
            bus.ex_mem_read   <= 1'b0;
            bus.ex_mem_write  <= 1'b0;
            bus.ex_reg_write  <= 1'b0;
            bus.ex_mem_to_reg <= 1'b0;
            bus.ex_branch     <= 1'b0;
            bus.ex_illegal    <= 1'b0;
        end else begin
            bus.ex_valid      <= 1'b1;
            bus.ex_pc         <= bus.if_id_pc;
            bus.ex_op1        <= op1;
            bus.ex_op2        <= op2;
            bus.ex_imm        <= imm;
            bus.ex_waddr      <= d_waddr;
            bus.ex_alu_op     <= d_alu_op;
            bus.ex_alu_src    <= d_alu_src;
            bus.ex_mem_read   <= d_mr;
            bus.ex_mem_write  <= d_mw;
            bus.ex_reg_write  <= d_rw;
            bus.ex_mem_to_reg <= d_m2r;
            bus.ex_branch     <= d_br;
            bus.ex_illegal    <= d_ill;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Stall-cycle and issue counters, free-running with wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.perf_stall_cnt <= 32'd0;
            bus.perf_issue_cnt <= 32'd0;
        end else begin
            if (bus.stall) bus.perf_stall_cnt <= bus.perf_stall_cnt + 32'd1;
            if (!bubble) bus.perf_issue_cnt <= bus.perf_issue_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized
// stimulus against a behavioural decode/issue model.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(32)) bus ();
    id_ex_stage_if #(.DW(32)) b0 ();

    id_ex_stage #(.DW(32), .ILLEGAL_AS_BUBBLE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    id_ex_stage #(.DW(32), .ILLEGAL_AS_BUBBLE(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    assign b0.if_id_valid = bus.if_id_valid;
    assign b0.if_id_instr = bus.if_id_instr;
    assign b0.if_id_pc    = bus.if_id_pc;
    assign b0.rd1         = bus.rd1;
    assign b0.rd2         = bus.rd2;
    assign b0.wb_we       = bus.wb_we;
    assign b0.wb_waddr    = bus.wb_waddr;
    assign b0.wb_wdata    = bus.wb_wdata;
    assign b0.flush       = bus.flush;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [4:0]  waddr;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
        logic        br;
        logic        ill;
    } ex_t;

    int checks = 0;
    int failures = 0;

    function automatic ex_t act_main();
        return {bus.ex_valid, bus.ex_pc, bus.ex_op1, bus.ex_op2, bus.ex_imm,
                bus.ex_waddr, bus.ex_alu_op, bus.ex_alu_src, bus.ex_mem_read,
                bus.ex_mem_write, bus.ex_reg_write, bus.ex_mem_to_reg,
                bus.ex_branch, bus.ex_illegal};
    endfunction

    function automatic ex_t act_alt();
        return {b0.ex_valid, b0.ex_pc, b0.ex_op1, b0.ex_op2, b0.ex_imm,
                b0.ex_waddr, b0.ex_alu_op, b0.ex_alu_src, b0.ex_mem_read,
                b0.ex_mem_write, b0.ex_reg_write, b0.ex_mem_to_reg,
                b0.ex_branch, b0.ex_illegal};
    endfunction

    function automatic logic [31:0] rtype(input int s, input int t,
                                          input int d, input logic [5:0] f);
        return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, f};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int s,
                                          input int t, input logic [15:0] im);
        return {op, 5'(s), 5'(t), im};
    endfunction

    // Reference: next ID/EX contents and stall from the architectural rules.
    function automatic ex_t model(
        input bit iab, input logic v, input logic [31:0] ins,
        input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic fl, input ex_t cur, output logic st
    );
        ex_t n;
        logic [4:0] s, t, d;
        bit ur, ut, ill, haz;
        s = ins[25:21];
        t = ins[20:16];
        d = ins[15:11];
        n = '0;
        ur = 0;
        ut = 0;
        ill = 0;
        case (ins[31:26])
            6'h00: begin
                ur = 1; ut = 1; n.rw = 1; n.waddr = d;
                case (ins[5:0])
                    6'h20: n.alu_op = 0;
                    6'h22: n.alu_op = 1;
                    6'h24: n.alu_op = 2;
                    6'h25: n.alu_op = 3;
                    6'h2A: n.alu_op = 4;
                    default: ill = 1;
                endcase
            end
            6'h23: begin
                ur = 1; n.alu_src = 1; n.mr = 1; n.rw = 1; n.m2r = 1;
                n.waddr = t;
            end
            6'h2B: begin ur = 1; ut = 1; n.alu_src = 1; n.mw = 1; end
            6'h04: begin ur = 1; ut = 1; n.alu_op = 1; n.br = 1; end
            6'h08: begin ur = 1; n.alu_src = 1; n.rw = 1; n.waddr = t; end
            default: ill = 1;
        endcase
        if (ill) begin
            ur = 0;
            ut = 0;
            n = '0;
            n.ill = 1;
        end
        haz = cur.valid && cur.mr && cur.waddr != 0 && v &&
              ((ur && cur.waddr == s) || (ut && cur.waddr == t));
        st = haz && !fl;
        if (fl || haz || !v || (ill && iab)) return '0;
        n.valid = 1;
        n.pc = pc;
        n.imm = {{16{ins[15]}}, ins[15:0]};
        n.op1 = (we && wa != 0 && wa == s) ? wd : (s == 0 ? 32'd0 : r1);
        n.op2 = (we && wa != 0 && wa == t) ? wd : (t == 0 ? 32'd0 : r2);
        return n;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic fl);
        @(negedge clk);
        bus.if_id_valid = v;
        bus.if_id_instr = ins;
        bus.if_id_pc = pc;
        bus.rd1 = r1;
        bus.rd2 = r2;
        bus.wb_we = we;
        bus.wb_waddr = wa;
        bus.wb_wdata = wd;
        bus.flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        #1;
        checks++;
        if (act_main() !== '0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_init got=%h stall=%b exp=0", act_main(), bus.stall);
        end
        rst = 1'b0;
        drive(1, itype(6'h23, 1, 4, 16'd8), 32'h10, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_issue valid=%b mr=%b exp=1/1", bus.ex_valid, bus.ex_mem_read);
        end
        drive(1, rtype(4, 2, 5, 6'h20), 32'h14, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_stall got=%b exp=1", bus.stall);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (act_main() !== '0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_async got=%h stall=%b exp=0", act_main(), bus.stall);
        end
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        drive(1, rtype(1, 2, 3, 6'h20), 32'h20, 32'd5, 32'd7, 1, 5'd1, 32'h100, 0);
        tick();
        checks++;
        if (bus.ex_op1 !== 32'h100 || bus.ex_op2 !== 32'd7 ||
            bus.ex_alu_op !== 3'd0 || bus.ex_waddr !== 5'd3 ||
            bus.ex_reg_write !== 1'b1 || bus.ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL bypass op1=%h op2=%h alu=%0d wa=%0d rw=%b exp=100/7/0/3/1",
                     bus.ex_op1, bus.ex_op2, bus.ex_alu_op, bus.ex_waddr, bus.ex_reg_write);
        end
    endtask

    task automatic test_load_use();
        drive(1, itype(6'h23, 1, 4, 16'd8), 32'h30, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        drive(1, rtype(4, 2, 5, 6'h20), 32'h34, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL loaduse_stall got=%b exp=1", bus.stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_bubble got=%b exp=0", bus.ex_valid);
        end
        drive(1, rtype(4, 2, 5, 6'h20), 32'h34, 32'h44, 32'h2, 1, 5'd4, 32'h99, 0);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL loaduse_release got=%b exp=0", bus.stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_waddr !== 5'd5 || bus.ex_op1 !== 32'h99) begin
            failures++;
            $display("FAIL loaduse_issue v=%b wa=%0d op1=%h exp=1/5/99",
                     bus.ex_valid, bus.ex_waddr, bus.ex_op1);
        end
    endtask

    task automatic test_back_to_back();
        drive(1, itype(6'h23, 1, 7, 16'd0), 32'h40, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        drive(1, itype(6'h23, 7, 8, 16'd4), 32'h44, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall got=%b exp=1", bus.stall);
        end
        tick();
        drive(1, itype(6'h23, 7, 8, 16'd4), 32'h44, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b1 || bus.ex_waddr !== 5'd8) begin
            failures++;
            $display("FAIL b2b_issue v=%b mr=%b wa=%0d exp=1/1/8",
                     bus.ex_valid, bus.ex_mem_read, bus.ex_waddr);
        end
    endtask

    task automatic test_flush_priority();
        drive(1, itype(6'h23, 1, 4, 16'd8), 32'h50, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        drive(1, rtype(4, 2, 5, 6'h20), 32'h54, 32'h1, 32'h2, 0, 5'd0, 32'h0, 1);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got=%b exp=0", bus.stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_bubble got=%b exp=0", bus.ex_valid);
        end
    endtask

    task automatic test_zero_reg();
        drive(1, itype(6'h08, 0, 0, 16'hFFFF), 32'h60, 32'hDEAD, 32'h2, 1, 5'd0, 32'h55, 0);
        tick();
        checks++;
        if (bus.ex_op1 !== 32'h0 || bus.ex_imm !== 32'hFFFFFFFF ||
            bus.ex_waddr !== 5'd0 || bus.ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_addi op1=%h imm=%h wa=%0d v=%b exp=0/ffffffff/0/1",
                     bus.ex_op1, bus.ex_imm, bus.ex_waddr, bus.ex_valid);
        end
        drive(1, itype(6'h23, 1, 0, 16'd4), 32'h64, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        drive(1, rtype(0, 0, 5, 6'h20), 32'h68, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL zero_lw_stall got=%b exp=0", bus.stall);
        end
        tick();
        checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_waddr !== 5'd5) begin
            failures++;
            $display("FAIL zero_lw_issue v=%b wa=%0d exp=1/5", bus.ex_valid, bus.ex_waddr);
        end
    endtask

    task automatic test_illegal();
        drive(1, itype(6'h3F, 1, 2, 16'h1234), 32'h70, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_illegal !== 1'b0) begin
            failures++;
            $display("FAIL illegal_bubble v=%b ill=%b exp=0/0", bus.ex_valid, bus.ex_illegal);
        end
        checks++;
        if (b0.ex_valid !== 1'b1 || b0.ex_illegal !== 1'b1 ||
            {b0.ex_waddr, b0.ex_alu_op, b0.ex_alu_src, b0.ex_mem_read,
             b0.ex_mem_write, b0.ex_reg_write, b0.ex_mem_to_reg,
             b0.ex_branch} !== 14'd0) begin
            failures++;
            $display("FAIL illegal_issue v=%b ill=%b rw=%b mr=%b exp=1/1/0/0",
                     b0.ex_valid, b0.ex_illegal, b0.ex_reg_write, b0.ex_mem_read);
        end
    endtask

    task automatic test_random();
        ex_t cur, cur0, nxt, nxt0;
        logic st, st0, hold;
        logic v;
        logic [31:0] ins, pc;
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        rst = 1'b0;
        cur = '0;
        cur0 = '0;
        hold = 0;
        v = 0;
        ins = 0;
        pc = 0;
        for (int i = 0; i < 500; i++) begin
            if (!hold) begin
                int k;
                int s, t, d;
                k = $urandom_range(0, 9);
                s = $urandom_range(0, 7);
                t = $urandom_range(0, 7);
                d = $urandom_range(0, 7);
                case (k)
                    0: ins = rtype(s, t, d, 6'h20);
                    1: ins = rtype(s, t, d, 6'h22);
                    2: ins = rtype(s, t, d, 6'h24);
                    3: ins = rtype(s, t, d, 6'h25);
                    4: ins = rtype(s, t, d, 6'h2A);
                    5: ins = itype(6'h23, s, t, 16'($urandom));
                    6: ins = itype(6'h2B, s, t, 16'($urandom));
                    7: ins = itype(6'h04, s, t, 16'($urandom));
                    8: ins = itype(6'h08, s, t, 16'($urandom));
                    default: ins = ($urandom_range(0, 1) == 0) ?
                                   itype(6'h3F, s, t, 16'($urandom)) :
                                   rtype(s, t, d, 6'h00);
                endcase
                pc = $urandom;
                v = ($urandom_range(0, 9) != 0);
            end
            drive(v, ins, pc, $urandom, $urandom, 1'($urandom),
                  5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) == 0));
            #1;
            nxt = model(1, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc,
                        bus.rd1, bus.rd2, bus.wb_we, bus.wb_waddr,
                        bus.wb_wdata, bus.flush, cur, st);
            nxt0 = model(0, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc,
                         bus.rd1, bus.rd2, bus.wb_we, bus.wb_waddr,
                         bus.wb_wdata, bus.flush, cur0, st0);
            checks++;
            if (bus.stall !== st || b0.stall !== st0) begin
                failures++;
                $display("FAIL rand_stall cyc=%0d got=%b/%b exp=%b/%b",
                         i, bus.stall, b0.stall, st, st0);
            end
            checks++;
            if (bus.rs_addr !== ins[25:21] || bus.rt_addr !== ins[20:16]) begin
                failures++;
                $display("FAIL rand_addr cyc=%0d got=%0d/%0d exp=%0d/%0d",
                         i, bus.rs_addr, bus.rt_addr, ins[25:21], ins[20:16]);
            end
            tick();
            checks++;
            if (act_main() !== nxt) begin
                failures++;
                $display("FAIL rand_ex cyc=%0d got=%h exp=%h", i, act_main(), nxt);
            end
            checks++;
            if (act_alt() !== nxt0) begin
                failures++;
                $display("FAIL rand_ex_alt cyc=%0d got=%h exp=%h", i, act_alt(), nxt0);
            end
            cur = nxt;
            cur0 = nxt0;
            hold = st;
        end
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        rst = 1'b0;
        drive(1, itype(6'h23, 1, 4, 16'd8), 32'h80, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        drive(1, rtype(4, 2, 5, 6'h20), 32'h84, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        drive(1, rtype(4, 2, 5, 6'h20), 32'h84, 32'h1, 32'h2, 0, 5'd0, 32'h0, 0);
        tick();
        drive(0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 5'd0, 32'h0, 0);
        tick();
        checks++;
        if (bus.perf_stall_cnt !== 32'd1 || bus.perf_issue_cnt !== 32'd2) begin
            failures++;
            $display("FAIL perf_cnt stall=%0d issue=%0d exp=1/2",
                     bus.perf_stall_cnt, bus.perf_issue_cnt);
        end
    endtask
`endif

    initial begin
        bus.if_id_valid = 0;
        bus.if_id_instr = 0;
        bus.if_id_pc = 0;
        bus.rd1 = 0;
        bus.rd2 = 0;
        bus.wb_we = 0;
        bus.wb_waddr = 0;
        bus.wb_wdata = 0;
        bus.flush = 0;
        test_reset();
        test_bypass();
        test_load_use();
        test_back_to_back();
        test_flush_priority();
        test_zero_reg();
        test_illegal();
        test_random();
`ifdef ID_EX_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/issue stage sitting directly downstream of the register file and IF/ID latch.
- Decodes the IF/ID instruction, selects register operands with write-back bypass, and detects load-use hazards. Stalls IF/ID on a hazard and inserts a bubble.
- Registers everything into the ID/EX pipeline register consumed by EX.
- Supported subset: R-type add/sub/and/or/slt (funct 20/22/24/25/2A), lw (23), sw (2B), beq (04), addi (08).

Parameters:
- DW, 32, datapath width of operands, immediate and PC.
- ILLEGAL_AS_BUBBLE, 1, 1: unknown opcode/funct issues a bubble; 0: issues with all controls zero but valid=1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_id_valid  in  1  IF/ID holds a real instruction
- if_id_instr  in  32  instruction word
- if_id_pc  in  DW  PC+4 of instruction
- rs_addr  out  5  instr[25:21], drives regfile read port 1 (combinational)
- rt_addr  out  5  instr[20:16], drives regfile read port 2 (combinational)
- rd1  in  DW  regfile read data 1
- rd2  in  DW  regfile read data 2
- wb_we  in  1  write-back enable this cycle
- wb_waddr  in  5  write-back destination
- wb_wdata  in  DW  write-back data
- flush  in  1  branch taken in EX; kill the instruction currently in ID
- stall  out  1  combinational; hold PC and IF/ID this cycle
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc  out  DW  registered if_id_pc
- ex_op1  out  DW  registered rs operand
- ex_op2  out  DW  registered rt operand
- ex_imm  out  DW  sign-extended instr[15:0]
- ex_waddr  out  5  destination: rd for R-type, rt for lw/addi, 0 otherwise
- ex_alu_op  out  3  0 add, 1 sub, 2 and, 3 or, 4 slt
- ex_alu_src  out  1  1 = ALU B operand is ex_imm
- ex_mem_read  out  1  lw
- ex_mem_write  out  1  sw
- ex_reg_write  out  1  R-type, lw, addi
- ex_mem_to_reg  out  1  lw
- ex_branch  out  1  beq
- ex_illegal  out  1  unknown opcode/funct was issued (valid only when ILLEGAL_AS_BUBBLE=0)

Behaviour:
- Reset: all ex_* outputs are 0 immediately on rst assertion (async) and held while rst is high. stall is 0 during reset.
- Operand select (combinational, registered at the clock edge):
  - op1 = wb_wdata if wb_we && wb_waddr!=0 && wb_waddr==rs; else 0 if rs==0; else rd1.
  - op2 is selected identically using rt.
  - The bypass covers the regfile write-at-edge/read-same-cycle gap.
- Sources used:
  - R-type, beq, sw: rs and rt.
  - lw, addi: rs only.
  - Illegal: none.
- Load-use hazard: hazard = ex_valid && ex_mem_read && ex_waddr!=0 && if_id_valid && (ex_waddr==rs used || ex_waddr==rt used).
- Priority, evaluated each rising edge:
  1. flush: load bubble, stall=0.
  2. hazard: stall=1, load bubble.
  3. !if_id_valid: load bubble.
  4. Otherwise: load the decoded instruction.
- Bubble: ex_valid and every control output are 0. ex_op1/op2/imm/pc/waddr are also 0.
- Latency: 1 cycle from IF/ID to ID/EX. A load-use hazard costs exactly 1 bubble. The stalled instruction issues the following cycle with the bypassed/updated operands.
- Back-to-back lw then dependent lw: the second lw stalls 1 cycle, then issues normally.
- Reset mid-stall clears the hazard source (ex_valid=0), so stall drops after reset.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_issue_cnt[31:0].
  - perf_stall_cnt increments on each cycle with stall=1.
  - perf_issue_cnt increments on each edge that loads ex_valid=1.
  - Both wrap at 2^32 and are cleared by rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: assert rst mid-stream with ex_valid=1 -> all ex_* read 0 before the next edge; stall=0.
- WB bypass: issue add $3,$1,$2 with rd1=5, rd2=7, wb_we=1, wb_waddr=1, wb_wdata=0x100 -> ex_op1=0x100, ex_op2=7, ex_alu_op=0, ex_waddr=3, ex_reg_write=1.
- Load-use: lw $4,8($1) then add $5,$4,$2 -> stall=1 for one cycle, one bubble (ex_valid=0), add issues on the next edge.
- Flush priority: flush=1 in the same cycle as a load-use hazard -> stall=0, ex_valid=0 next cycle.
- $0 handling: addi $0,$0,-1 with rd1=0xDEAD and wb_waddr=0, wb_we=1 -> ex_op1=0, ex_imm=0xFFFFFFFF, ex_waddr=0; a following lw writing $0 causes no stall.
- Illegal opcode 0x3F with ILLEGAL_AS_BUBBLE=1 -> ex_valid=0; with 0 -> ex_valid=1, ex_illegal=1, all controls 0.
